// File: rtl/ctrl_frame_tx_engine.sv
// Control-frame transmit engine: bus-loaded frame buffer streamed byte-wise
// to a set of PHY-TX FIFOs under a mutex handshake.
module ctrl_frame_tx_engine #(
  parameter int          NUM_PORTS = 4,
  parameter int          RAM_WORDS = 64,
  parameter logic [7:0]  CFG_SEL   = 8'h15,
  parameter logic [7:0]  RAM_SEL   = 8'h05
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iomem_valid,
  output logic                 iomem_ready,
  input  logic [3:0]           iomem_wstrb,
  input  logic [31:0]          iomem_addr,
  input  logic [31:0]          iomem_wdata,
  output logic [31:0]          iomem_rdata,
  output logic [7:0]           o_fifo_din,
  output logic                 o_fifo_del,
  input  logic [NUM_PORTS-1:0] port_afull,
  output logic [NUM_PORTS-1:0] port_wren,
  output logic [NUM_PORTS-1:0] mutex_req,
  input  logic [NUM_PORTS-1:0] mutex_val
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int NP = NUM_PORTS;
  localparam logic [12:0] LMAX = 13'(4 * RAM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_TX, S_TERM, S_END
  } state_e;

  state_e        state_q, state_d;
  logic          rdy_q, rdy_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [11:0]   cnt_q, cnt_d;
  logic [15:0]   wcnt_q, wcnt_d;
  logic [11:0]   len_q, len_d;
  logic [NP-1:0] mask_q, mask_d;
  logic [15:0]   tmo_q, tmo_d;
  logic [15:0]   txc_q, txc_d;
  logic [15:0]   abc_q, abc_d;
  logic [1:0]    err_q, err_d;
  logic [NP-1:0] mreq_q, mreq_d;
  logic [NP-1:0] wren_q, wren_d;
  logic [7:0]    din_q, din_d;
  logic          del_q, del_d;
  logic          done_q, done_d;

  logic [31:0] mem [RAM_WORDS];

  logic          cfg_hit, ram_hit, req, wr, busy, free;
  logic          ctrl_wr, tmo_wr, err_wr, start, abort;
  logic [AW-1:0] widx;
  logic [1:0]    ra;
  logic [31:0]   rd, tx_word;
  logic [7:0]    tx_byte;
  logic [15:0]   mask_ext, mask_m, tmo_m;
  logic [11:0]   len_m;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign cfg_hit = iomem_addr[31:24] == CFG_SEL;
  assign ram_hit = iomem_addr[31:24] == RAM_SEL;
  assign req     = iomem_valid && !rdy_q && (cfg_hit || ram_hit);
  assign wr      = req && (|iomem_wstrb);
  assign widx    = iomem_addr[AW+1:2];
  assign ra      = iomem_addr[3:2];
  assign busy    = state_q != S_IDLE;
  assign free    = (port_afull & mask_q) == '0;
  assign ctrl_wr = wr && cfg_hit && ra == 2'd0;
  assign tmo_wr  = wr && cfg_hit && ra == 2'd2;
  assign err_wr  = wr && cfg_hit && ra == 2'd3;
  assign start   = ctrl_wr && iomem_wstrb[3] && iomem_wdata[31];
  assign abort   = ctrl_wr && iomem_wstrb[3] && iomem_wdata[28];

  assign mask_ext = 16'(mask_q);
  assign mask_m = {
    iomem_wstrb[1] ? iomem_wdata[15:8] : mask_ext[15:8],
    iomem_wstrb[0] ? iomem_wdata[7:0]  : mask_ext[7:0]};
  assign len_m = {
    iomem_wstrb[3] ? iomem_wdata[27:24] : len_q[11:8],
    iomem_wstrb[2] ? iomem_wdata[23:16] : len_q[7:0]};
  assign tmo_m = {
    iomem_wstrb[1] ? iomem_wdata[15:8] : tmo_q[15:8],
    iomem_wstrb[0] ? iomem_wdata[7:0]  : tmo_q[7:0]};

  assign tx_word = mem[cnt_q[AW+1:2]];
  assign tx_byte = tx_word[{cnt_q[1:0], 3'b000} +: 8];

  wire unused_ok = ^{iomem_addr, mask_m, cnt_q};

  always_comb begin
    rd = '0;
    if (ram_hit) begin
      rd = mem[widx];
    end else begin
      unique case (ra)
        2'd0: rd = {1'b0, !busy, busy, 1'b0, len_q, mask_ext};
        2'd1: rd = {txc_q, abc_q};
        2'd2: rd = {16'h0, tmo_q};
        2'd3: rd = {30'h0, err_q};
      endcase
    end
  end

  // The frame buffer holds its contents across reset.
  always_ff @(posedge clk) begin
    if (wr && ram_hit && !busy) begin
      for (int b = 0; b < 4; b++) begin
        if (iomem_wstrb[b]) mem[widx][8*b +: 8] <= iomem_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rdy_d   = req;
    rdata_d = req ? rd : '0;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    len_d   = len_q;
    mask_d  = mask_q;
    tmo_d   = tmo_q;
    txc_d   = txc_q;
    abc_d   = abc_q;
    err_d   = err_q;
    mreq_d  = mreq_q;
    wren_d  = '0;
    din_d   = '0;
    del_d   = 1'b0;
    done_d  = done_q;

    if (ctrl_wr && !busy) begin
      len_d  = len_m;
      mask_d = mask_m[NP-1:0];
    end
    if (tmo_wr && !busy) tmo_d = tmo_m;
    if (err_wr && iomem_wstrb[0]) err_d = err_q & ~iomem_wdata[1:0];

    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        wcnt_d = '0;
        if (start && !abort) begin
          if (len_d == '0 || mask_d == '0 || {1'b0, len_d} > LMAX) begin
            err_d[0] = 1'b1;
          end else begin
            state_d = S_WAIT;
            mreq_d  = mask_d;
          end
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_END;
          abc_d   = sat_inc(abc_q);
        end else if (mutex_val == mreq_q && free) begin
          state_d = S_TX;
        end else if (tmo_q != '0 && wcnt_q + 16'd1 == tmo_q) begin
          state_d  = S_END;
          err_d[1] = 1'b1;
          abc_d    = sat_inc(abc_q);
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      S_TX: begin
        if (abort) begin
          state_d = S_TERM;
          abc_d   = sat_inc(abc_q);
        end else if (free) begin
          wren_d = mask_q;
          din_d  = tx_byte;
          cnt_d  = cnt_q + 12'd1;
          if (cnt_q == len_q - 12'd1) begin
            del_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_END;
          end
        end
      end
      S_TERM: begin
        // Close the truncated frame with a single delimited pad byte.
        if (free) begin
          wren_d  = mask_q;
          del_d   = 1'b1;
          state_d = S_END;
        end
      end
      S_END: begin
        mreq_d  = '0;
        done_d  = 1'b0;
        state_d = S_IDLE;
        if (done_q) txc_d = sat_inc(txc_q);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      len_q   <= '0;
      mask_q  <= '0;
      tmo_q   <= '0;
      txc_q   <= '0;
      abc_q   <= '0;
      err_q   <= '0;
      mreq_q  <= '0;
      wren_q  <= '0;
      din_q   <= '0;
      del_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      len_q   <= len_d;
      mask_q  <= mask_d;
      tmo_q   <= tmo_d;
      txc_q   <= txc_d;
      abc_q   <= abc_d;
      err_q   <= err_d;
      mreq_q  <= mreq_d;
      wren_q  <= wren_d;
      din_q   <= din_d;
      del_q   <= del_d;
      done_q  <= done_d;
    end
  end

  assign iomem_ready = rdy_q;
  assign iomem_rdata = rdata_q;
  assign o_fifo_din  = din_q;
  assign o_fifo_del  = del_q;
  assign port_wren   = wren_q;
  assign mutex_req   = mreq_q;

endmodule

// File: tb/tb_ctrl_frame_tx_engine.sv
// Directed bench for ctrl_frame_tx_engine: register table plus
// hand-written frame, stall, abort, timeout and reset sequences.
module tb_ctrl_frame_tx_engine;

  localparam logic [31:0] CTRL = 32'h1500_0000;
  localparam logic [31:0] STAT = 32'h1500_0004;
  localparam logic [31:0] TMO  = 32'h1500_0008;
  localparam logic [31:0] ERR  = 32'h1500_000C;
  localparam logic [31:0] RAM  = 32'h0500_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = '0;
  logic [31:0] iomem_addr = '0;
  logic [31:0] iomem_wdata = '0;
  logic [31:0] iomem_rdata;
  logic [7:0]  o_fifo_din;
  logic        o_fifo_del;
  logic [3:0]  port_afull = '0;
  logic [3:0]  port_wren;
  logic [3:0]  mutex_req;
  logic [3:0]  mutex_val;
  logic        grant_en = 1'b0;

  always #5 clk = ~clk;
  assign mutex_val = grant_en ? mutex_req : '0;

  ctrl_frame_tx_engine dut (
    .clk(clk), .rst(rst),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .o_fifo_din(o_fifo_din), .o_fifo_del(o_fifo_del),
    .port_afull(port_afull), .port_wren(port_wren),
    .mutex_req(mutex_req), .mutex_val(mutex_val)
  );

  typedef struct packed {
    logic [3:0] wren;
    logic [7:0] din;
    logic       del;
  } wr_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  wr_t  q[$];
  int   mreq_cycles = 0;
  int   nvec = 0;
  int   nbad = 0;
  vec_t tbl[26];

  always @(negedge clk) begin
    if (port_wren != '0) q.push_back('{port_wren, o_fifo_din, o_fifo_del});
    if (mutex_req != '0) mreq_cycles++;
  end

  function automatic logic [7:0] eb(input int k);
    return 8'(k * 37 + 11);
  endfunction

  function automatic logic [31:0] ew(input int i);
    return {eb(4*i+3), eb(4*i+2), eb(4*i+1), eb(4*i)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus(input bit w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] r);
    int n = 0;
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = a;
    iomem_wdata = d;
    iomem_wstrb = w ? s : 4'h0;
    do begin
      @(negedge clk);
      n++;
    end while (!iomem_ready && n < 20);
    if (!iomem_ready) begin
      nvec++;
      nbad++;
      $display("FAIL bus_ack: no ready for addr %h", a);
    end
    r = iomem_rdata;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    logic [31:0] r;
    bus(1'b1, a, d, s, r);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b0, a, 32'h0, 4'h0, r);
    chk(nm, r, exp);
  endtask

  task automatic wait_idle(input string nm);
    logic [31:0] r;
    int n = 0;
    do begin
      bus(1'b0, CTRL, 32'h0, 4'h0, r);
      n++;
    end while (!r[30] && n < 200);
    if (!r[30]) begin
      nvec++;
      nbad++;
      $display("FAIL %s_idle: ctrl %h still busy", nm, r);
    end
  endtask

  task automatic wait_q(input string nm, input int cnt);
    int n = 0;
    while (q.size() < cnt && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() < cnt) begin
      nvec++;
      nbad++;
      $display("FAIL %s_wait: %0d writes, needed %0d", nm, q.size(), cnt);
    end
  endtask

  task automatic chk_frame(input string nm, input int len,
                           input logic [3:0] m);
    int bad = 0;
    chk({nm, "_count"}, q.size(), len);
    for (int i = 0; i < q.size() && i < len; i++) begin
      if (q[i].din !== eb(i) || q[i].wren !== m ||
          q[i].del !== (i == len - 1)) bad++;
    end
    chk({nm, "_bytes"}, bad, 0);
  endtask

  task automatic setv(input int i, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] e);
    tbl[i] = '{w, a, d, s, e};
  endtask

  initial begin
    logic [31:0] r;
    int hits;
    int qs0;

    setv(0,  0, CTRL, 0, 0, 32'h4000_0000);
    setv(1,  0, STAT, 0, 0, 32'h0000_0000);
    setv(2,  0, TMO,  0, 0, 32'h0000_0000);
    setv(3,  0, ERR,  0, 0, 32'h0000_0000);
    setv(4,  1, CTRL, 32'h00C0_00FF, 4'hF, 0);
    setv(5,  0, CTRL, 0, 0, 32'h40C0_000F);
    setv(6,  1, CTRL, 32'h0000_0000, 4'hC, 0);
    setv(7,  0, CTRL, 0, 0, 32'h4000_000F);
    setv(8,  1, TMO,  32'hABCD_1234, 4'hF, 0);
    setv(9,  0, TMO,  0, 0, 32'h0000_1234);
    setv(10, 1, TMO,  32'h0000_0000, 4'h3, 0);
    setv(11, 0, TMO,  0, 0, 32'h0000_0000);
    setv(12, 1, RAM + 8, 32'h1122_3344, 4'hF, 0);
    setv(13, 1, RAM + 8, 32'hAABB_CCDD, 4'h5, 0);
    setv(14, 0, RAM + 8, 0, 0, 32'h11BB_33DD);
    setv(15, 1, CTRL, 32'h8000_0003, 4'hF, 0);
    setv(16, 0, ERR,  0, 0, 32'h0000_0001);
    setv(17, 0, CTRL, 0, 0, 32'h4000_0003);
    setv(18, 1, ERR,  32'h0000_0001, 4'h1, 0);
    setv(19, 0, ERR,  0, 0, 32'h0000_0000);
    setv(20, 1, CTRL, 32'h9010_0001, 4'hF, 0);
    setv(21, 0, CTRL, 0, 0, 32'h4010_0001);
    setv(22, 0, STAT, 0, 0, 32'h0000_0000);
    setv(23, 1, CTRL, 32'h8FFF_0001, 4'hF, 0);
    setv(24, 0, ERR,  0, 0, 32'h0000_0001);
    setv(25, 1, ERR,  32'h0000_0001, 4'h1, 0);

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {31'h0, iomem_ready} | iomem_rdata | {24'h0, o_fifo_din} |
        {31'h0, o_fifo_del} | {28'h0, port_wren} | {28'h0, mutex_req}, 0);
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      bus(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, r);
      if (!tbl[i].wr) chk($sformatf("vec%0d", i), r, tbl[i].exp);
    end

    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0600_0000;
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (iomem_ready) hits++;
    end
    iomem_valid = 1'b0;
    chk("unmapped_no_ack", hits, 0);

    for (int i = 0; i < 16; i++) wr32(RAM + 32'(4*i), ew(i), 4'hF);
    rd_chk("ram_word5", RAM + 20, ew(5));

    grant_en = 1'b1;
    q.delete();
    wr32(CTRL, 32'h8040_0005, 4'hF);
    wait_idle("f64");
    chk_frame("f64", 64, 4'b0101);
    rd_chk("f64_status", STAT, 32'h0001_0000);

    q.delete();
    wr32(CTRL, 32'h8005_0002, 4'hF);
    hits = 0;
    while (!o_fifo_del && hits < 100) begin
      @(negedge clk);
      hits++;
    end
    chk("f5_del_seen", o_fifo_del, 1);
    repeat (2) @(negedge clk);
    chk("f5_mreq_drop", mutex_req, 0);
    wait_idle("f5");
    chk_frame("f5", 5, 4'b0010);

    q.delete();
    wr32(CTRL, 32'h8020_0003, 4'hF);
    wait_q("stall", 10);
    port_afull = 4'b0010;
    qs0 = q.size();
    repeat (3) begin
      @(negedge clk);
      #1;
    end
    chk("stall_no_write", q.size(), qs0);
    port_afull = 4'b0000;
    wait_idle("stall");
    chk_frame("stall", 32, 4'b0011);
    rd_chk("stall_status", STAT, 32'h0003_0000);

    q.delete();
    wr32(CTRL, 32'h8028_0001, 4'hF);
    wait_q("abort", 10);
    port_afull = 4'b0001;
    wr32(CTRL, 32'h1000_0000, 4'h8);
    repeat (2) @(negedge clk);
    chk("abort_held", q.size(), 10);
    port_afull = 4'b0000;
    wait_idle("abort");
    chk("abort_count", q.size(), 11);
    hits = 0;
    for (int i = 0; i < 10 && i < q.size(); i++)
      if (q[i].din !== eb(i) || q[i].del !== 1'b0) hits++;
    chk("abort_prefix", hits, 0);
    if (q.size() > 0)
      chk("abort_term", {23'h0, q[q.size()-1]}, {23'h0, 4'b0001, 8'h00, 1'b1});
    rd_chk("abort_status", STAT, 32'h0003_0001);

    grant_en = 1'b0;
    q.delete();
    wr32(TMO, 32'h0000_0008, 4'hF);
    mreq_cycles = 0;
    wr32(CTRL, 32'h8004_0001, 4'hF);
    wait_idle("tmo");
    chk("tmo_err", 0, 0);
    rd_chk("tmo_err_reg", ERR, 32'h0000_0002);
    chk("tmo_no_write", q.size(), 0);
    chk("tmo_req_cycles", mreq_cycles, 9);
    rd_chk("tmo_status", STAT, 32'h0003_0002);
    wr32(ERR, 32'h0000_0002, 4'h1);
    wr32(TMO, 32'h0000_0000, 4'hF);
    rd_chk("tmo_err_clr", ERR, 32'h0);

    wr32(CTRL, 32'h8008_0001, 4'hF);
    rd_chk("busy_ctrl", CTRL, 32'h2008_0001);
    wr32(RAM, 32'hDEAD_BEEF, 4'hF);
    wr32(CTRL, 32'h0FFF_000F, 4'hF);
    rd_chk("busy_ctrl_frozen", CTRL, 32'h2008_0001);
    wr32(CTRL, 32'h1000_0000, 4'h8);
    wait_idle("wait_abort");
    rd_chk("busy_ram_kept", RAM, ew(0));
    chk("wait_abort_nowr", q.size(), 0);
    rd_chk("wait_abort_status", STAT, 32'h0003_0003);

    grant_en = 1'b1;
    q.delete();
    wr32(CTRL, 32'h8040_0001, 4'hF);
    wait_q("rst", 5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_frame", {mutex_req, port_wren}, 0);
    rst = 1'b0;
    rd_chk("rst_ctrl", CTRL, 32'h4000_0000);
    rd_chk("rst_status", STAT, 32'h0);
    rd_chk("rst_ram_kept", RAM + 12, ew(3));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
